lfsr_hv_stream_gen: RTL and testbench

- Parametrised LFSR + phase-shifter generator of pseudo-random hypervector element streams, for the HDC encoder / DQN weight-init path.
- Generalises the fixed 20-bit generator: arbitrary LFSR width and taps, channel spacing via an elaboration-computed jump matrix, runtime seed and beat count, valid/ready backpressure, abort, last/done flags.
- Consumers: HDC bind/bundle units and on-chip RAM fill logic.

---
 rtl/lfsr_hv_pkg.sv | 71 +++++++
 rtl/lfsr_phase_shifter.sv | 38 +++
 rtl/lfsr_hv_stream_gen.sv | 135 +++++++++++++
 tb/tb_lfsr_hv_stream_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_hv_pkg.sv
// Shared types and elaboration-time GF(2) helpers for the LFSR hypervector generator.
// Latency: n/a (package; all functions are evaluated at elaboration or as pure combinational logic).
// Backpressure: n/a.
package lfsr_hv_pkg;

    // Widest LFSR the jump-matrix helpers support.
    localparam int LFSR_MAX_W = 64;

    // Square GF(2) matrix stored as row masks: row r selects the state bits
    // whose XOR gives next-state bit r.
    typedef logic [LFSR_MAX_W-1:0][LFSR_MAX_W-1:0] gf2_mat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } gen_state_t;

    function automatic logic parity(input logic [LFSR_MAX_W-1:0] v);
        return ^v;
    endfunction

    // One LFSR step: bits shift down by one and the MSB takes the tap parity.
    function automatic gf2_mat_t lfsr_step_matrix(input int width,
                                                  input logic [LFSR_MAX_W-1:0] taps);
        gf2_mat_t m;
        m = '0;
        for (int r = 0; r < width - 1; r++) begin
            m[r][r+1] = 1'b1;
        end
        m[width-1] = taps;
        return m;
    endfunction

    function automatic gf2_mat_t gf2_mat_mul(input gf2_mat_t a, input gf2_mat_t b,
                                             input int width = LFSR_MAX_W);
        gf2_mat_t c;
        c = '0;
        for (int r = 0; r < width; r++) begin
            for (int k = 0; k < width; k++) begin
                if (a[r][k]) begin
                    c[r] = c[r] ^ b[k];
                end
            end
        end
        return c;
    endfunction

    // Square-and-multiply keeps every loop short, even for large step counts.
    function automatic gf2_mat_t gf2_mat_pow(input gf2_mat_t m, input int n,
                                             input int width = LFSR_MAX_W);
        gf2_mat_t result;
        gf2_mat_t base;
        int       e;
        result = '0;
        base   = m;
        e      = n;
        for (int i = 0; i < width; i++) begin
            result[i][i] = 1'b1;
        end
        while (e > 0) begin
            if (e[0]) begin
                result = gf2_mat_mul(result, base, width);
            end
            base = gf2_mat_mul(base, base, width);
            e    = e >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_phase_shifter.sv
// Phase shifter: channel i is bit 0 of the LFSR state advanced by i*CHANNEL_SEPARATION steps.
// Latency: purely combinational from lfsr.
// Backpressure: none; output is stable whenever lfsr holds.
// Ports: lfsr (current LFSR state) -> channels (CHANNELS phase-shifted bits).
module lfsr_phase_shifter
    import lfsr_hv_pkg::*;
#(
    parameter int                    LFSR_WIDTH         = 20,
    parameter logic [LFSR_WIDTH-1:0] TAP_MASK           = 20'h80005,
    parameter int                    CHANNELS           = 1536,
    parameter int                    CHANNEL_SEPARATION = 625
) (
    input  logic [LFSR_WIDTH-1:0] lfsr,
    output logic [CHANNELS-1:0]   channels
);

    // Jump matrix: CHANNEL_SEPARATION LFSR steps folded into one GF(2) transform.
    localparam gf2_mat_t JUMP = gf2_mat_pow(
        lfsr_step_matrix(LFSR_WIDTH, LFSR_MAX_W'(TAP_MASK)), CHANNEL_SEPARATION, LFSR_WIDTH);

    logic [LFSR_WIDTH-1:0] s;
    logic [LFSR_WIDTH-1:0] s_nxt;

    // Walk the jump chain s_i = J * s_{i-1}; each hop yields one channel.
    always_comb begin
        channels = '0;
        s        = lfsr;
        s_nxt    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            channels[i] = s[0];
            for (int r = 0; r < LFSR_WIDTH; r++) begin
                s_nxt[r] = parity(LFSR_MAX_W'(JUMP[r][LFSR_WIDTH-1:0] & s));
            end
            s = s_nxt;
        end
    end

endmodule

// File: rtl/lfsr_hv_stream_gen.sv
// Streams beats of ELEMENTS_PER_CLOCK pseudo-random signed elements from a seeded LFSR + phase shifter.
// Latency: beat 0 valid the cycle after start_i; done_o one cycle after the last handshake.
// Backpressure: valid/ready; on a stall valid stays high and data holds (lfsr only steps on handshake).
// Ports: clk, rst_n; start_i/seed_i/num_beats_i launch a run; abort_i kills it;
//        out_valid_o/out_ready_i/out_data_o/out_last_o carry beats; busy_o, done_o report status.
module lfsr_hv_stream_gen
    import lfsr_hv_pkg::*;
#(
    parameter int                    LFSR_WIDTH         = 20,
    parameter logic [LFSR_WIDTH-1:0] TAP_MASK           = 20'h80005,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED       = {{(LFSR_WIDTH-1){1'b0}}, 1'b1},
    parameter int                    CHANNELS           = 1536,
    parameter int                    CHANNEL_SEPARATION = 625,
    parameter int                    BIT_WIDTH          = 8,
    parameter int                    ELEMENTS_PER_CLOCK = 192,
    parameter int                    BEAT_W             = 16
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             start_i,
    input  logic [LFSR_WIDTH-1:0]                            seed_i,
    input  logic [BEAT_W-1:0]                                num_beats_i,
    input  logic                                             abort_i,
    output logic                                             out_valid_o,
    input  logic                                             out_ready_i,
    output logic [ELEMENTS_PER_CLOCK-1:0][BIT_WIDTH-1:0]     out_data_o,
    output logic                                             out_last_o,
    output logic                                             busy_o,
    output logic                                             done_o
);

    localparam int DATA_W = ELEMENTS_PER_CLOCK * BIT_WIDTH;

    if (LFSR_WIDTH < 3 || LFSR_WIDTH > LFSR_MAX_W) begin : g_bad_width
        $error("lfsr_hv_stream_gen: LFSR_WIDTH out of range");
    end
    if (CHANNELS < DATA_W) begin : g_bad_channels
        $error("lfsr_hv_stream_gen: CHANNELS < ELEMENTS_PER_CLOCK*BIT_WIDTH");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("lfsr_hv_stream_gen: DEFAULT_SEED must be nonzero");
    end

    gen_state_t            state_q, state_d;
    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [BEAT_W-1:0]     cnt_q, cnt_d;
    logic                  zero_done_q, zero_done_d;
    logic [LFSR_WIDTH-1:0] run_seed;
    logic [LFSR_WIDTH-1:0] lfsr_stepped;
    logic [CHANNELS-1:0]   channels;

    // An all-zero state would lock the LFSR, so a zero seed falls back to the default.
    assign run_seed     = (seed_i == '0) ? DEFAULT_SEED : seed_i;
    assign lfsr_stepped = {parity(LFSR_MAX_W'(lfsr_q & TAP_MASK)), lfsr_q[LFSR_WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        zero_done_d = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        busy_o      = (state_q != IDLE);
        // A zero-beat run never leaves IDLE; its done pulse comes from a flag.
        done_o      = zero_done_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_beats_i != '0) begin
                        lfsr_d  = run_seed;
                        cnt_d   = num_beats_i - 1'b1;
                        state_d = RUN;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                out_valid_o = 1'b1;
                out_last_o  = (cnt_q == '0);
                // Abort wins over a same-cycle handshake and leaves lfsr untouched.
                if (abort_i) begin
                    state_d = IDLE;
                end else if (out_ready_i) begin
                    lfsr_d = lfsr_stepped;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= DEFAULT_SEED;
            cnt_q       <= '0;
            zero_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            zero_done_q <= zero_done_d;
        end
    end

    lfsr_phase_shifter #(
        .LFSR_WIDTH         (LFSR_WIDTH),
        .TAP_MASK           (TAP_MASK),
        .CHANNELS           (CHANNELS),
        .CHANNEL_SEPARATION (CHANNEL_SEPARATION)
    ) u_shifter (
        .lfsr     (lfsr_q),
        .channels (channels)
    );

    // Element k occupies channels [k*BIT_WIDTH +: BIT_WIDTH], which is exactly the packed layout.
    assign out_data_o = channels[DATA_W-1:0];

    if (CHANNELS > DATA_W) begin : g_spare_channels
        logic unused_channels;
        assign unused_channels = ^channels[CHANNELS-1:DATA_W];
    end

endmodule

// File: tb/tb_lfsr_hv_stream_gen.sv
// Bench for lfsr_hv_stream_gen: a small directed configuration plus the default configuration,
// both checked every cycle against a bit-stream model of the 20-bit LFSR (taps 0,2,19).
module tb_lfsr_hv_stream_gen;

    typedef bit bitq_t[];

    localparam int SEP_D = 625;
    localparam int CH_D  = 1536;
    localparam int LEN_S = 32 + 512;
    localparam int LEN_D = SEP_D * (CH_D - 1) + 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // small instance: 4 elements x 8 bits, 32 channels, separation 1
    logic        s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b0;
    logic [19:0] s_seed = '0;
    logic [15:0] s_num  = '0;
    logic        s_valid, s_last, s_busy, s_done;
    logic [3:0][7:0] s_data;

    // default instance
    logic        d_start = 1'b0, d_abort = 1'b0, d_ready = 1'b0;
    logic [19:0] d_seed = '0;
    logic [15:0] d_num  = '0;
    logic        d_valid, d_last, d_busy, d_done;
    logic [191:0][7:0] d_data;

    int n_vec = 0;
    int n_err = 0;

    // model: per instance (0 = small, 1 = default)
    bit    m_act[2];
    bit    m_flush[2];
    bit    m_zdone[2];
    int    m_beat[2];
    int    m_total[2];
    bitq_t xs_s;
    bitq_t xs_d;

    always #5 clk = ~clk;

    lfsr_hv_stream_gen #(
        .LFSR_WIDTH(20), .TAP_MASK(20'h80005), .DEFAULT_SEED(20'h00001),
        .CHANNELS(32), .CHANNEL_SEPARATION(1), .BIT_WIDTH(8),
        .ELEMENTS_PER_CLOCK(4), .BEAT_W(16)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .start_i(s_start), .seed_i(s_seed),
        .num_beats_i(s_num), .abort_i(s_abort), .out_valid_o(s_valid),
        .out_ready_i(s_ready), .out_data_o(s_data), .out_last_o(s_last),
        .busy_o(s_busy), .done_o(s_done)
    );

    lfsr_hv_stream_gen dut_d (
        .clk(clk), .rst_n(rst_n), .start_i(d_start), .seed_i(d_seed),
        .num_beats_i(d_num), .abort_i(d_abort), .out_valid_o(d_valid),
        .out_ready_i(d_ready), .out_data_o(d_data), .out_last_o(d_last),
        .busy_o(d_busy), .done_o(d_done)
    );

    // x[t] = bit 0 of the LFSR after t steps; state after t steps holds x[t+19..t].
    function automatic bitq_t make_stream(logic [19:0] seed, int len);
        bitq_t x;
        x = new[len];
        for (int t = 0; t < 20; t++) x[t] = seed[t];
        for (int t = 20; t < len; t++) x[t] = x[t-20] ^ x[t-18] ^ x[t-1];
        return x;
    endfunction

    function automatic logic [31:0] exp_s(int b);
        logic [31:0] e;
        for (int c = 0; c < 32; c++) e[c] = xs_s[b + c];
        return e;
    endfunction

    function automatic logic [1535:0] exp_d(int b);
        logic [1535:0] e;
        for (int c = 0; c < CH_D; c++) e[c] = xs_d[b + SEP_D * c];
        return e;
    endfunction

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level view of a run: active beats, then one completion cycle.
    task automatic model_step(int id, logic start, logic [19:0] seed, logic [15:0] num,
                              logic abort, logic ready);
        bit was_act;
        bit was_flush;
        was_act     = m_act[id];
        was_flush   = m_flush[id];
        m_zdone[id] = 1'b0;
        m_flush[id] = 1'b0;
        if (was_act) begin
            if (abort) begin
                m_act[id] = 1'b0;
            end else if (ready) begin
                m_beat[id]++;
                if (m_beat[id] == m_total[id]) begin
                    m_act[id]   = 1'b0;
                    m_flush[id] = 1'b1;
                end
            end
        end else if (!was_flush && start) begin
            if (num == 16'd0) begin
                m_zdone[id] = 1'b1;
            end else begin
                m_act[id]   = 1'b1;
                m_beat[id]  = 0;
                m_total[id] = int'(num);
                if (id == 0) xs_s = make_stream((seed == 20'd0) ? 20'd1 : seed, LEN_S);
                else         xs_d = make_stream((seed == 20'd0) ? 20'd1 : seed, LEN_D);
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] = 1'b0; m_flush[i] = 1'b0; m_zdone[i] = 1'b0;
                m_beat[i] = 0;   m_total[i] = 0;
            end
        end else begin
            model_step(0, s_start, s_seed, s_num, s_abort, s_ready);
            model_step(1, d_start, d_seed, d_num, d_abort, d_ready);
        end
    end

    task automatic cmp_flags(string tag, int id, logic v, logic l, logic b, logic d);
        logic ev, el, eb, ed;
        ev = rst_n && m_act[id];
        el = ev && (m_beat[id] == m_total[id] - 1);
        eb = rst_n && (m_act[id] || m_flush[id]);
        ed = rst_n && (m_flush[id] || m_zdone[id]);
        cmp({tag, "_valid"}, 64'(v), 64'(ev));
        cmp({tag, "_last"},  64'(l), 64'(el));
        cmp({tag, "_busy"},  64'(b), 64'(eb));
        cmp({tag, "_done"},  64'(d), 64'(ed));
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        logic [1535:0] ed;
        bit            shown;
        cmp_flags("s", 0, s_valid, s_last, s_busy, s_done);
        cmp_flags("d", 1, d_valid, d_last, d_busy, d_done);
        if (rst_n && m_act[0]) cmp("s_data", 64'(s_data), 64'(exp_s(m_beat[0])));
        if (rst_n && m_act[1]) begin
            ed = exp_d(m_beat[1]);
            n_vec++;
            if (d_data !== ed) begin
                n_err++;
                shown = 1'b0;
                for (int k = 0; k < 192; k++) begin
                    if (!shown && d_data[k] !== ed[k*8 +: 8]) begin
                        $display("FAIL d_data at %0t beat %0d: element %0d got %0h, expected %0h",
                                 $time, m_beat[1], k, d_data[k], ed[k*8 +: 8]);
                        shown = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(string name);
        int cyc;
        cyc = 0;
        while ((s_busy || d_busy) && cyc < 200) begin
            tick();
            cyc++;
        end
        cmp({name, "_idle_in_budget"}, 64'(s_busy | d_busy), 64'd0);
    endtask

    initial begin
        int hs;
        int cyc;

        // reset
        repeat (3) tick();
        cmp("rst_s_valid", 64'(s_valid), 64'd0);
        cmp("rst_s_busy",  64'(s_busy),  64'd0);
        cmp("rst_d_done",  64'(d_done),  64'd0);
        cmp("rst_d_last",  64'(d_last),  64'd0);
        rst_n = 1'b1;
        tick();

        // directed: seed 1, 3 beats, always ready
        s_seed = 20'd1; s_num = 16'd3; s_ready = 1'b1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cmp("dir_beat0_valid", 64'(s_valid), 64'd1);
        cmp("dir_beat0_data",  64'(s_data),  64'hFFF0_0001);
        cmp("model_beat0",     64'(exp_s(0)), 64'hFFF0_0001);
        cmp("dir_beat0_last",  64'(s_last),  64'd0);
        tick();
        cmp("dir_beat1_data",  64'(s_data),  64'hFFF8_0000);
        cmp("dir_beat1_last",  64'(s_last),  64'd0);
        tick();
        cmp("dir_beat2_last",  64'(s_last),  64'd1);
        tick();
        cmp("dir_flush_valid", 64'(s_valid), 64'd0);
        cmp("dir_flush_done",  64'(s_done),  64'd1);
        cmp("dir_flush_busy",  64'(s_busy),  64'd1);
        tick();
        cmp("dir_idle_done",   64'(s_done),  64'd0);
        cmp("dir_idle_busy",   64'(s_busy),  64'd0);

        // zero seed maps to the default seed
        s_seed = 20'd0; s_num = 16'd1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cmp("seed0_beat0_data", 64'(s_data), 64'hFFF0_0001);
        wait_idle("seed0");

        // default config: 5 beats with ready pattern 1,0,0,1,...
        d_seed = 20'($urandom_range(1, 20'hFFFFF)); d_num = 16'd5; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        cyc = 0; hs = 0;
        while (d_busy && cyc < 100) begin
            d_ready = (cyc % 3 == 0);
            if (d_valid && d_ready) hs++;
            tick();
            cyc++;
        end
        cmp("stall_run_handshakes", 64'(hs), 64'd5);
        d_ready = 1'b1;
        wait_idle("stall_run");

        // abort on beat 2 of 10 together with ready
        d_seed = 20'($urandom_range(1, 20'hFFFFF)); d_num = 16'd10; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        tick();
        tick();
        d_abort = 1'b1;
        tick();
        d_abort = 1'b0;
        cmp("abort_valid", 64'(d_valid), 64'd0);
        cmp("abort_done",  64'(d_done),  64'd0);
        cmp("abort_busy",  64'(d_busy),  64'd0);
        d_num = 16'd2; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        cmp("abort_restart_valid", 64'(d_valid), 64'd1);
        wait_idle("abort_restart");

        // zero-beat run
        s_num = 16'd0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cmp("zero_valid", 64'(s_valid), 64'd0);
        cmp("zero_done",  64'(s_done),  64'd1);
        cmp("zero_busy",  64'(s_busy),  64'd0);
        tick();
        cmp("zero_done_clear", 64'(s_done), 64'd0);

        // start while busy is ignored
        d_seed = 20'($urandom_range(1, 20'hFFFFF)); d_num = 16'd6; d_ready = 1'b0; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        tick();
        d_seed = 20'h12345; d_num = 16'd2; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        cyc = 0; hs = 0;
        d_ready = 1'b1;
        while (d_busy && cyc < 100) begin
            if (d_valid && d_ready) hs++;
            tick();
            cyc++;
        end
        cmp("busy_start_beats", 64'(hs), 64'd6);
        wait_idle("busy_start");

        // asynchronous reset mid-run
        d_num = 16'd8; d_start = 1'b1;
        tick();
        d_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        cmp("async_rst_valid", 64'(d_valid), 64'd0);
        cmp("async_rst_busy",  64'(d_busy),  64'd0);
        cmp("async_rst_last",  64'(d_last),  64'd0);
        cmp("async_rst_done",  64'(d_done),  64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // randomized traffic on both instances
        for (int i = 0; i < 300; i++) begin
            s_start = ($urandom % 5 == 0);
            s_seed  = ($urandom % 4 == 0) ? 20'd0 : 20'($urandom);
            s_num   = 16'($urandom_range(0, 6));
            s_abort = ($urandom % 12 == 0);
            s_ready = 1'($urandom % 2);
            d_start = ($urandom % 20 == 0);
            d_seed  = ($urandom % 4 == 0) ? 20'd0 : 20'($urandom);
            d_num   = 16'($urandom_range(0, 4));
            d_abort = ($urandom % 16 == 0);
            d_ready = 1'($urandom % 2);
            tick();
        end
        s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
        d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b1;
        wait_idle("random");
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
